button_event: RTL and testbench

Press-event decoder that sits directly downstream of the button debouncer. It takes the debouncer's clean but clock-asynchronous level and re-times it into the system `clk` domain. It then classifies each press as a short press or a long press and emits single-cycle event pulses. The menu and control FSMs consume these pulses instead of raw button levels.

---
 rtl/button_pkg.sv | 13 +
 rtl/sync_2ff.sv | 25 ++
 rtl/button_event.sv | 118 +++++++++++
 tb/tb_button_event.sv | 118 +++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and constants for the button-input blocks (debouncer consumers,
// event decoders).
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        LONG
    } btn_state_t;

    localparam int BTN_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// Flop-chain synchronizer that re-times one asynchronous level into the clk
// domain. The chain depth comes from BTN_SYNC_STAGES.
module sync_2ff
    import button_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [BTN_SYNC_STAGES-1:0] chain;

    // NOTE: sequential state uses non-blocking (<=) so every flop in the chain samples the pre-edge value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[BTN_SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[BTN_SYNC_STAGES-1];

endmodule

// File: rtl/button_event.sv
// Press-event decoder: synchronizes the debounced button level and emits one
// short_press or long_press pulse per press. Long-press detection is compiled
// only when BUTTON_LONG_PRESS_EN is defined; otherwise every press is short.
module button_event
    import button_pkg::*;
#(
    parameter int LONG_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pressed,
    output logic short_press,
    output logic long_press
);

    if (LONG_CYCLES < 2) begin : g_bad_long_cycles
        $error("button_event: LONG_CYCLES must be 2 or more");
    end

    logic       s;
    btn_state_t state;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in),
        .q     (s)
    );

`ifdef BUTTON_LONG_PRESS_EN
    localparam int CNT_W = $clog2(LONG_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LONG_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            pressed     <= 1'b0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
        end else begin
            // NOTE: pulses default low each cycle so they can only ever last one clock.
            short_press <= 1'b0;
            long_press  <= 1'b0;
            case (state)
                IDLE: begin
                    if (s) begin
                        state   <= PRESS;
                        cnt     <= CNT_W'(1);
                        pressed <= 1'b1;
                    end
                end
                PRESS: begin
                    // Release wins over the terminal count, so a release on that edge is short.
                    if (!s) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        pressed     <= 1'b0;
                        short_press <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state      <= LONG;
                        long_press <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LONG: begin
                    if (!s) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        pressed <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    pressed <= 1'b0;
                end
            endcase
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pressed     <= 1'b0;
            short_press <= 1'b0;
        end else begin
            short_press <= 1'b0;
            case (state)
                IDLE: begin
                    if (s) begin
                        state   <= PRESS;
                        pressed <= 1'b1;
                    end
                end
                PRESS: begin
                    if (!s) begin
                        state       <= IDLE;
                        pressed     <= 1'b0;
                        short_press <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    pressed <= 1'b0;
                end
            endcase
        end
    end

    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_event.sv
// Directed self-checking bench for button_event with LONG_CYCLES=8; expected
// long-press behaviour follows whether BUTTON_LONG_PRESS_EN is defined.
module tb_button_event;

    localparam int LC = 8;
`ifdef BUTTON_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif
    localparam int HOLD_FOREVER = 1000;

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic pressed;
    logic short_press;
    logic long_press;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    button_event #(.LONG_CYCLES(LC)) dut (
        .clk         (clk),
        .reset       (reset),
        .in          (btn_in),
        .pressed     (pressed),
        .short_press (short_press),
        .long_press  (long_press)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs k edges after the first edge that sees btn_in high,
    // for a button held for `hold` edges.
    task automatic check_cycle(input string name, input int hold, input int k);
        bit is_long;
        bit exp_pressed;
        bit exp_short;
        bit exp_long;
        is_long     = LONG_EN && (hold >= LC);
        exp_pressed = (k >= 2) && (k <= hold + 1);
        exp_long    = is_long && (k == LC + 1);
        exp_short   = !is_long && (k == hold + 2);
        check($sformatf("%s k=%0d pressed", name, k), pressed, exp_pressed);
        check($sformatf("%s k=%0d short_press", name, k), short_press, exp_short);
        check($sformatf("%s k=%0d long_press", name, k), long_press, exp_long);
    endtask

    task automatic press(input string name, input int hold);
        for (int k = 0; k <= hold + 4; k++) begin
            btn_in = (k < hold);
            tick();
            check_cycle(name, hold, k);
        end
        tick();
        tick();
    endtask

    initial begin
        reset  = 1'b1;
        btn_in = 1'b0;
        #3;
        check("por pressed", pressed, 1'b0);
        check("por short_press", short_press, 1'b0);
        check("por long_press", long_press, 1'b0);
        tick();
        tick();
        #2;
        reset = 1'b0;
        tick();
        check("idle pressed", pressed, 1'b0);
        check("idle short_press", short_press, 1'b0);
        check("idle long_press", long_press, 1'b0);

        press("short3", 3);
        press("single", 1);
        press("hold7", 7);
        press("hold8", 8);
        press("long20", 20);

        // Held through a reset: outputs drop at once, then a fresh press is counted.
        btn_in = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check_cycle("pre_rst", HOLD_FOREVER, k);
        end
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst pressed", pressed, 1'b0);
        check("mid_rst short_press", short_press, 1'b0);
        check("mid_rst long_press", long_press, 1'b0);
        tick();
        check("in_rst pressed", pressed, 1'b0);
        #2;
        reset = 1'b0;
        press("post_rst", 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
